// File: rtl/csr_access_unit.sv
// ============================================================================
// Module   : csr_access_unit
// Purpose  : Zicsr initiator. Runs CSRRW/CSRRS/CSRRC as separate read and
//            write cycles, checks privilege and read-only legality, and
//            returns the old CSR value or an illegal-instruction flag.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module csr_access_unit #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [1:0]      req_op,
    input  logic [11:0]     req_addr,
    input  logic [XLEN-1:0] req_src,
    input  logic            req_src_zero,
    input  logic [1:0]      cur_mode,
    output logic            resp_valid,
    input  logic            resp_ready,
    output logic [XLEN-1:0] resp_rdata,
    output logic            resp_exc,
    output logic [11:0]     csr_raddr,
    input  logic [XLEN-1:0] csr_rdata,
    output logic [11:0]     csr_waddr,
    output logic            csr_we,
    output logic [XLEN-1:0] csr_wdata
);

    localparam logic [1:0] OP_RW = 2'b01;
    localparam logic [1:0] OP_RS = 2'b10;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t            state;
    logic [1:0]        op;
    logic [11:0]       addr;
    logic [XLEN-1:0]   src;
    logic              src_zero;
    logic [1:0]        mode;
    logic [XLEN-1:0]   old_val;
    logic              exc_pending;

    logic              do_write;
    logic              illegal;
    logic [XLEN-1:0]   wdata_next;

    // Legality depends only on the latched micro-op, never on the read data.
    assign do_write = (op == OP_RW) || !src_zero;
    assign illegal  = (op == 2'b00) || (addr[9:8] > mode) ||
                      ((addr[11:10] == 2'b11) && do_write);

    always_comb begin
        wdata_next = csr_rdata & ~src;
        if (op == OP_RW)
            wdata_next = src;
        else if (op == OP_RS)
            wdata_next = csr_rdata | src;
    end

    assign req_ready = (state == IDLE) && !rst;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            op          <= 2'b00;
            addr        <= 12'h000;
            src         <= '0;
            src_zero    <= 1'b0;
            mode        <= 2'b00;
            old_val     <= '0;
            exc_pending <= 1'b0;
            resp_valid  <= 1'b0;
            resp_rdata  <= '0;
            resp_exc    <= 1'b0;
            csr_raddr   <= 12'h000;
            csr_waddr   <= 12'h000;
            csr_we      <= 1'b0;
            csr_wdata   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        op        <= req_op;
                        addr      <= req_addr;
                        src       <= req_src;
                        src_zero  <= req_src_zero;
                        mode      <= cur_mode;
                        csr_raddr <= req_addr;
                        state     <= READ;
                    end
                end
                READ: begin
                    old_val     <= csr_rdata;
                    exc_pending <= illegal;
                    csr_we      <= do_write && !illegal;
                    csr_waddr   <= addr;
                    csr_wdata   <= wdata_next;
                    state       <= WRITE;
                end
                WRITE: begin
                    csr_we     <= 1'b0;
                    resp_valid <= 1'b1;
                    resp_exc   <= exc_pending;
                    resp_rdata <= exc_pending ? '0 : old_val;
                    state      <= RESP;
                end
                RESP: begin
                    if (resp_ready) begin
                        resp_valid <= 1'b0;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_csr_access_unit.sv
// ============================================================================
// Module   : tb_csr_access_unit
// Purpose  : Directed and randomized checks of csr_access_unit against a
//            behavioural CSR-file model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_csr_access_unit;

    localparam int          XLEN   = 32;
    localparam logic [31:0] HARTID = 32'h0000_0005;

    logic            clk = 1'b0;
    logic            rst;
    logic            req_valid;
    logic            req_ready;
    logic [1:0]      req_op;
    logic [11:0]     req_addr;
    logic [XLEN-1:0] req_src;
    logic            req_src_zero;
    logic [1:0]      cur_mode;
    logic            resp_valid;
    logic            resp_ready;
    logic [XLEN-1:0] resp_rdata;
    logic            resp_exc;
    logic [11:0]     csr_raddr;
    logic [XLEN-1:0] csr_rdata;
    logic [11:0]     csr_waddr;
    logic            csr_we;
    logic [XLEN-1:0] csr_wdata;

    int n_cmp = 0;
    int n_bad = 0;

    bit [31:0] mem  [4096];
    bit [31:0] refm [4096];

    always #5 clk = ~clk;

    csr_access_unit #(.XLEN(XLEN)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_addr(req_addr), .req_src(req_src), .req_src_zero(req_src_zero),
        .cur_mode(cur_mode),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_rdata(resp_rdata), .resp_exc(resp_exc),
        .csr_raddr(csr_raddr), .csr_rdata(csr_rdata),
        .csr_waddr(csr_waddr), .csr_we(csr_we), .csr_wdata(csr_wdata)
    );

    // mhartid is a fixed read-only value; everything else lives in mem.
    assign csr_rdata = (csr_raddr == 12'hF14) ? HARTID : mem[csr_raddr];

    always @(posedge clk) begin
        if (csr_we) mem[csr_waddr] <= csr_wdata;
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] model_read(input logic [11:0] a);
        return (a == 12'hF14) ? HARTID : refm[a];
    endfunction

    task automatic do_op(input logic [1:0] op, input logic [11:0] a, input logic [31:0] s,
                         input logic sz, input logic [1:0] m, input int hold);
        logic        dw, ill, exp_we;
        logic [31:0] old, nv, exp_rd, rd0;
        logic        ex0;
        int          n;
        dw     = (op == 2'b01) || !sz;
        ill    = (op == 2'b00) || (a[9:8] > m) || (a[11:10] == 2'b11 && dw);
        old    = model_read(a);
        nv     = (op == 2'b01) ? s : (op == 2'b10) ? (old | s) : (old & ~s);
        exp_we = dw && !ill;
        exp_rd = ill ? 32'h0 : old;

        chk("ready_idle", req_ready, 1);
        req_valid = 1; req_op = op; req_addr = a; req_src = s;
        req_src_zero = sz; cur_mode = m; resp_ready = 0;
        @(posedge clk); #1;
        req_valid = 0; req_op = 2'($urandom); req_addr = 12'($urandom);
        req_src = $urandom; cur_mode = 2'($urandom);

        n = 1;
        while (!resp_valid && n < 10) begin
            chk("ready_busy", req_ready, 0);
            if (n == 1) chk("raddr", csr_raddr, a);
            if (n == 2) begin
                chk("we", csr_we, exp_we);
                if (exp_we) begin
                    chk("waddr", csr_waddr, a);
                    chk("wdata", csr_wdata, nv);
                end
            end else begin
                chk("we_off", csr_we, 0);
            end
            @(posedge clk); #1;
            n++;
        end
        chk("latency", n, 3);
        chk("rdata", resp_rdata, exp_rd);
        chk("exc", resp_exc, ill);
        chk("we_resp", csr_we, 0);

        rd0 = resp_rdata; ex0 = resp_exc;
        repeat (hold) begin
            cur_mode = 2'($urandom);
            @(posedge clk); #1;
            chk("hold_valid", resp_valid, 1);
            chk("hold_rdata", resp_rdata, rd0);
            chk("hold_exc", resp_exc, ex0);
            chk("hold_ready", req_ready, 0);
            chk("hold_we", csr_we, 0);
        end
        resp_ready = 1;
        @(posedge clk); #1;
        resp_ready = 0;
        chk("hs_valid", resp_valid, 0);
        chk("hs_ready", req_ready, 1);

        if (exp_we && a != 12'hF14) refm[a] = nv;
        chk("mem", mem[a], refm[a]);
    endtask

    logic [11:0] addr_pool [8] = '{12'h340, 12'hF14, 12'h105, 12'h300,
                                   12'h001, 12'hC00, 12'h7C0, 12'h141};

    initial begin
        logic [31:0] s;
        logic        sz;
        rst = 1; req_valid = 0; req_op = 0; req_addr = 0; req_src = 0;
        req_src_zero = 0; cur_mode = 0; resp_ready = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready", req_ready, 0);
        chk("rst_valid", resp_valid, 0);
        chk("rst_exc", resp_exc, 0);
        chk("rst_we", csr_we, 0);
        chk("rst_rdata", resp_rdata, 0);
        chk("rst_wdata", csr_wdata, 0);
        chk("rst_raddr", csr_raddr, 0);
        chk("rst_waddr", csr_waddr, 0);
        @(negedge clk) rst = 0;
        #1 chk("rel_ready", req_ready, 1);

        do_op(2'b01, 12'h340, 32'hDEADBEEF, 0, 2'b11, 0);
        do_op(2'b10, 12'h340, 32'h000000F0, 0, 2'b11, 0);
        do_op(2'b11, 12'h340, 32'hFFFF0000, 0, 2'b11, 0);
        chk("plan_rc_value", mem[12'h340], 32'h0000BEFF);
        do_op(2'b10, 12'hF14, 32'h0, 1, 2'b11, 0);
        do_op(2'b01, 12'hF14, 32'h1234, 0, 2'b11, 0);
        do_op(2'b01, 12'h105, 32'h1, 0, 2'b00, 0);
        do_op(2'b01, 12'h105, 32'h80000000, 0, 2'b01, 0);
        do_op(2'b10, 12'h300, 32'h1, 0, 2'b01, 0);
        do_op(2'b00, 12'h340, 32'h5, 0, 2'b11, 0);
        do_op(2'b11, 12'h340, 32'h0, 1, 2'b11, 0);
        do_op(2'b01, 12'h340, 32'hAAAA5555, 0, 2'b11, 5);

        // Reset while the write strobe is high: no write, no response.
        req_valid = 1; req_op = 2'b01; req_addr = 12'h340; req_src = 32'h12345678;
        req_src_zero = 0; cur_mode = 2'b11;
        @(posedge clk); #1 req_valid = 0;
        @(posedge clk); #1;
        chk("midrst_we_before", csr_we, 1);
        #2 rst = 1;
        #1;
        chk("midrst_we_async", csr_we, 0);
        chk("midrst_ready", req_ready, 0);
        @(negedge clk) rst = 0;
        #1 chk("midrst_ready_rel", req_ready, 1);
        repeat (4) begin
            @(posedge clk); #1;
            chk("midrst_no_resp", resp_valid, 0);
        end
        chk("midrst_mem", mem[12'h340], refm[12'h340]);
        do_op(2'b10, 12'h340, 32'h0F000000, 0, 2'b11, 0);

        for (int i = 0; i < 150; i++) begin
            sz = ($urandom_range(0, 3) == 0);
            s  = sz ? 32'h0 : $urandom;
            do_op(2'($urandom), addr_pool[$urandom_range(0, 7)], s, sz,
                  2'($urandom), int'($urandom_range(0, 3)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
